// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Boot-time controller between the SoC UART receiver and instruction/data RAM.
//   With sw_uart_upgrade_b low at reset it holds the CPU in reset, streams
//   RAM_SIZE bytes from the UART into RAM as little-endian words, sends an
//   8-bit checksum over UART TX, then releases the CPU. Otherwise the CPU is
//   released straight away.
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   sw_uart_upgrade_b   0 = perform upgrade (sampled only in IDLE)
//   rx_valid, rx_data   one-cycle pulse per received byte
//   tx_busy             UART transmitter busy
//   tx_valid, tx_data   one-cycle checksum send request
//   ram_we, ram_addr,   word write strobe, word address, write data
//   ram_wdata
//   cpu_hold            1 = keep CPU in reset
//   done                image loaded and checksum sent (sticky)
//   err                 inter-byte timeout (sticky until rst)
module uart_boot_loader #(
  parameter int XLEN           = 32,
  parameter int RAM_SIZE       = 16'h4000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sw_uart_upgrade_b,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          tx_busy,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  output logic                          ram_we,
  output logic [$clog2(RAM_SIZE/4)-1:0] ram_addr,
  output logic [XLEN-1:0]               ram_wdata,
  output logic                          cpu_hold,
  output logic                          done,
  output logic                          err
);

  localparam int CW = $clog2(RAM_SIZE) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, ACK, RUN, ERR} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   byte_cnt;
  logic [TW-1:0]   idle_cnt;
  logic [23:0]     byte_buf;
  logic [7:0]      csum;
  logic            we_q;
  logic            accept;
  logic            last_byte;
  logic            timeout;
  logic            send;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_byte  = 1'b0;
    timeout    = 1'b0;
    send       = 1'b0;
    case (state)
      IDLE: state_next = sw_uart_upgrade_b ? RUN : LOAD;
      LOAD: begin
        accept    = rx_valid;
        last_byte = rx_valid && (byte_cnt == CW'(RAM_SIZE - 1));
        // no timeout until the first byte has arrived
        timeout   = !rx_valid && (byte_cnt != '0) &&
                    (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
        if (last_byte)    state_next = ACK;
        else if (timeout) state_next = ERR;
      end
      ACK: begin
        send = !tx_busy;
        if (send) state_next = RUN;
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      byte_buf  <= '0;
      csum      <= '0;
      we_q      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      we_q     <= 1'b0;
      tx_valid <= 1'b0;
      if (accept) begin
        // newest byte enters at the top, so the first byte of a word ends up in [7:0]
        byte_buf <= {rx_data, byte_buf[23:8]};
        csum     <= csum + rx_data;
        byte_cnt <= byte_cnt + 1'b1;
        idle_cnt <= '0;
        if (byte_cnt[1:0] == 2'd3) begin
          we_q      <= 1'b1;
          ram_addr  <= byte_cnt[CW-2:2];
          ram_wdata <= {rx_data, byte_buf};
        end
      end else if (state == LOAD && byte_cnt != '0) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (send) begin
        tx_valid <= 1'b1;
        tx_data  <= csum;
      end
      if (tx_valid) done <= 1'b1;
      if (timeout)  err  <= 1'b1;
      cpu_hold <= (state != RUN);
    end
  end

  // a write pending from the previous edge must not reach RAM during reset
  assign ram_we = we_q & ~rst;

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader
//   Directed bench for uart_boot_loader with RAM_SIZE=16, TIMEOUT_CYCLES=50.
//   Inputs change 1 time unit after the rising edge; outputs are checked there
//   or logged on the falling edge.
module tb_uart_boot_loader;

  localparam int RAM_SIZE = 16;
  localparam int TIMEOUT  = 50;
  localparam logic [31:0] IMG [4] = '{32'h03020100, 32'h07060504,
                                      32'h0B0A0908, 32'h0F0E0D0C};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw_uart_upgrade_b = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_busy = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        ram_we;
  logic [1:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int vectors = 0;
  int misc    = 0;
  int cyc     = 0;
  int nwr     = 0;
  int ntx     = 0;
  logic [1:0]  wa [64];
  logic [31:0] wd [64];
  int          wc [64];
  logic [7:0]  td [64];
  int          tc [64];
  int          acc [32];
  int          base, tbase;

  uart_boot_loader #(
    .XLEN(32),
    .RAM_SIZE(RAM_SIZE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_uart_upgrade_b(sw_uart_upgrade_b),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_busy(tx_busy),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cycle stamp = index of the rising edge that produced the value
  always @(negedge clk) begin
    if (ram_we && nwr < 64) begin
      wa[nwr] = ram_addr;
      wd[nwr] = ram_wdata;
      wc[nwr] = cyc;
      nwr = nwr + 1;
    end
    if (tx_valid && ntx < 64) begin
      td[ntx] = tx_data;
      tc[ntx] = cyc;
      ntx = ntx + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic sw);
    rst = 1'b1;
    rx_valid = 1'b0;
    tx_busy = 1'b0;
    sw_uart_upgrade_b = sw;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int idx);
    rx_valid = 1'b1;
    rx_data = b;
    tick(1);
    acc[idx] = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic load_bytes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i != 0) tick(gap);
      send_byte(8'(i), i);
    end
  endtask

  task automatic check_image(input int b);
    chk("wr_count", 32'(nwr - b), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wr%0d_addr", k), 32'(wa[b+k]), 32'(k));
      chk($sformatf("wr%0d_data", k), wd[b+k], IMG[k]);
      chk($sformatf("wr%0d_cyc", k), 32'(wc[b+k]), 32'(acc[4*k+3]));
    end
  endtask

  // called on the cycle right after the last byte was accepted, tx_busy low
  task automatic check_ack_tail(input int t);
    chk("last_we", 32'(ram_we), 32'd1);
    chk("last_addr", 32'(ram_addr), 32'd3);
    chk("last_data", ram_wdata, 32'h0F0E0D0C);
    chk("ack_txv0", 32'(tx_valid), 32'd0);
    tick(1);
    chk("ack_txv", 32'(tx_valid), 32'd1);
    chk("ack_txd", 32'(tx_data), 32'h78);
    chk("ack_done0", 32'(done), 32'd0);
    chk("ack_hold1", 32'(cpu_hold), 32'd1);
    tick(1);
    chk("run_txv", 32'(tx_valid), 32'd0);
    chk("run_done", 32'(done), 32'd1);
    chk("run_hold", 32'(cpu_hold), 32'd0);
    chk("tx_count", 32'(ntx - t), 32'd1);
  endtask

  initial begin
    // 1: switch high -> immediate release, no activity
    do_reset(1'b1);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    base = nwr; tbase = ntx;
    tick(1);
    chk("sw_hold_e1", 32'(cpu_hold), 32'd1);
    tick(1);
    chk("sw_hold_e2", 32'(cpu_hold), 32'd0);
    sw_uart_upgrade_b = 1'b0;
    load_bytes(4, 1);
    tick(20);
    chk("sw_nwr", 32'(nwr - base), 32'd0);
    chk("sw_ntx", 32'(ntx - tbase), 32'd0);
    chk("sw_done", 32'(done), 32'd0);
    chk("sw_err", 32'(err), 32'd0);
    chk("sw_hold", 32'(cpu_hold), 32'd0);

    // 2: spaced bytes, long wait before the first one
    do_reset(1'b0);
    tick(80);
    chk("prewait_err", 32'(err), 32'd0);
    chk("prewait_hold", 32'(cpu_hold), 32'd1);
    base = nwr; tbase = ntx;
    load_bytes(16, 9);
    check_ack_tail(tbase);
    tick(5);
    check_image(base);
    chk("t2_err", 32'(err), 32'd0);

    // 3: back-to-back bytes, extras after the last are ignored, pin ignored
    do_reset(1'b0);
    tick(2);
    sw_uart_upgrade_b = 1'b1;
    base = nwr; tbase = ntx;
    for (int i = 0; i < 20; i++) begin
      rx_valid = 1'b1;
      rx_data = 8'(i);
      tick(1);
      acc[i] = cyc;
    end
    rx_valid = 1'b0;
    tick(3);
    check_image(base);
    chk("b2b_ntx", 32'(ntx - tbase), 32'd1);
    chk("b2b_txd", 32'(td[tbase]), 32'h78);
    chk("b2b_txcyc", 32'(tc[tbase]), 32'(acc[15] + 1));
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_hold", 32'(cpu_hold), 32'd0);

    // 4: timeout after 5 bytes
    do_reset(1'b0);
    tick(1);
    base = nwr; tbase = ntx;
    load_bytes(5, 3);
    tick(49);
    chk("to_err49", 32'(err), 32'd0);
    tick(1);
    chk("to_err50", 32'(err), 32'd1);
    chk("to_hold", 32'(cpu_hold), 32'd1);
    tick(10);
    chk("to_err_sticky", 32'(err), 32'd1);
    chk("to_hold_late", 32'(cpu_hold), 32'd1);
    chk("to_done", 32'(done), 32'd0);
    chk("to_nwr", 32'(nwr - base), 32'd1);
    chk("to_addr", 32'(wa[base]), 32'd0);
    chk("to_data", wd[base], 32'h03020100);
    chk("to_wcyc", 32'(wc[base]), 32'(acc[3]));
    chk("to_ntx", 32'(ntx - tbase), 32'd0);

    // 5: transmitter busy for 100 cycles after the last byte
    do_reset(1'b0);
    tick(1);
    base = nwr; tbase = ntx;
    tx_busy = 1'b1;
    load_bytes(16, 9);
    tick(100);
    chk("busy_ntx", 32'(ntx - tbase), 32'd0);
    chk("busy_done", 32'(done), 32'd0);
    chk("busy_hold", 32'(cpu_hold), 32'd1);
    tx_busy = 1'b0;
    tick(1);
    chk("busy_txv", 32'(tx_valid), 32'd1);
    chk("busy_txd", 32'(tx_data), 32'h78);
    tick(1);
    chk("busy_txv_off", 32'(tx_valid), 32'd0);
    chk("busy_run_done", 32'(done), 32'd1);
    chk("busy_run_hold", 32'(cpu_hold), 32'd0);
    chk("busy_ntx1", 32'(ntx - tbase), 32'd1);
    check_image(base);

    // 6: reset mid-load, then a full reload
    do_reset(1'b0);
    tick(1);
    base = nwr;
    load_bytes(6, 2);
    rst = 1'b1;
    tick(1);
    chk("mid_hold", 32'(cpu_hold), 32'd1);
    chk("mid_we", 32'(ram_we), 32'd0);
    chk("mid_addr", 32'(ram_addr), 32'd0);
    chk("mid_wdata", ram_wdata, 32'd0);
    chk("mid_txv", 32'(tx_valid), 32'd0);
    chk("mid_txd", 32'(tx_data), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_err", 32'(err), 32'd0);
    chk("mid_nwr", 32'(nwr - base), 32'd1);
    rst = 1'b0;
    tick(1);
    base = nwr; tbase = ntx;
    load_bytes(16, 9);
    check_ack_tail(tbase);
    tick(5);
    check_image(base);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
